// File: rtl/input_capture_pkg.sv
// Shared constants for the board input capture block: register map and
// default input width (SW[9:0] on bits 9:0, KEY[3:0] on bits 13:10).
package input_capture_pkg;

   localparam int DEFAULT_WIDTH = 14;

   typedef enum logic [1:0] {
      ADDR_DATA         = 2'd0,
      ADDR_IRQ_MASK     = 2'd1,
      ADDR_EDGE_CAPTURE = 2'd2,
      ADDR_EDGE_SEL     = 2'd3
   } reg_addr_e;

endpackage

// File: rtl/input_capture_debounce_bit.sv
// One board input bit: 2-flop synchronizer, tick-sampled history and
// debounced value with rise/fall pulses on accepted transitions.
module debounce_bit #(
   parameter int STABLE_SAMPLES = 4
) (
   input  logic clk,
   input  logic reset,
   input  logic in_raw,
   input  logic tick,
   input  logic primed,
   input  logic prime_load,
   output logic debounced,
   output logic rise,
   output logic fall
);

   logic                      sync_q1;
   logic                      sync_q2;
   logic [STABLE_SAMPLES-1:0] hist;
   logic [STABLE_SAMPLES-1:0] hist_next;
   logic                      all_ones;
   logic                      all_zeros;
   logic                      change;

   // Decisions use the history including this tick's sample.
   assign hist_next = {hist[STABLE_SAMPLES-2:0], sync_q2};
   assign all_ones  = &hist_next;
   assign all_zeros = ~|hist_next;
   assign change    = tick & primed &
                      ((all_ones & ~debounced) | (all_zeros & debounced));
   assign rise      = change & ~debounced;
   assign fall      = change & debounced;

   always_ff @(posedge clk) begin
      if (reset) begin
         sync_q1   <= 1'b0;
         sync_q2   <= 1'b0;
         hist      <= '0;
         debounced <= 1'b0;
      end else begin
         sync_q1 <= in_raw;
         sync_q2 <= sync_q1;
         if (tick) begin
            hist <= hist_next;
         end
         // Priming loads the newest sample silently; no edge is produced.
         if (prime_load) begin
            debounced <= sync_q2;
         end else if (change) begin
            debounced <= ~debounced;
         end
      end
   end

endmodule

// File: rtl/input_capture.sv
// Debounced SW/KEY capture with edge-capture interrupt, exposed as an
// Avalon-MM slave on the HPS lightweight bridge.
module input_capture
   import input_capture_pkg::*;
#(
   parameter int WIDTH          = DEFAULT_WIDTH,
   parameter int TICK_CYCLES    = 250000,
   parameter int STABLE_SAMPLES = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] in_raw,
   input  logic [1:0]       address,
   input  logic             read,
   input  logic             write,
   input  logic [31:0]      writedata,
   output logic [31:0]      readdata,
   output logic             irq
);

   localparam int CNT_W   = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
   localparam int PRIME_W = $clog2(STABLE_SAMPLES + 1);

   logic [CNT_W-1:0]   tick_cnt;
   logic               tick;
   logic [PRIME_W-1:0] prime_cnt;
   logic               primed;
   logic               prime_load;

   logic [WIDTH-1:0] data;
   logic [WIDTH-1:0] rise;
   logic [WIDTH-1:0] fall;
   logic [WIDTH-1:0] edge_hit;
   logic [WIDTH-1:0] w1c;
   logic [WIDTH-1:0] irq_mask;
   logic [WIDTH-1:0] edge_cap;
   logic [WIDTH-1:0] edge_sel;
   logic [31:0]      rd_value;
   logic             wdata_unused;

   assign wdata_unused = ^writedata[31:WIDTH];

   assign tick       = (tick_cnt == CNT_W'(TICK_CYCLES - 1));
   assign prime_load = tick & ~primed & (prime_cnt == PRIME_W'(STABLE_SAMPLES - 1));

   always_ff @(posedge clk) begin
      if (reset) begin
         tick_cnt  <= '0;
         prime_cnt <= '0;
         primed    <= 1'b0;
      end else begin
         tick_cnt <= tick ? '0 : tick_cnt + CNT_W'(1);
         if (prime_load) begin
            primed <= 1'b1;
         end else if (tick && !primed) begin
            prime_cnt <= prime_cnt + PRIME_W'(1);
         end
      end
   end

   for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      debounce_bit #(
         .STABLE_SAMPLES(STABLE_SAMPLES)
      ) u_debounce (
         .clk        (clk),
         .reset      (reset),
         .in_raw     (in_raw[i]),
         .tick       (tick),
         .primed     (primed),
         .prime_load (prime_load),
         .debounced  (data[i]),
         .rise       (rise[i]),
         .fall       (fall[i])
      );
   end

   // Bus semantics: read and write are single-cycle strobes with no
   // waitrequest; readdata is valid exactly one cycle after read, else 0.
   assign edge_hit = (edge_sel & rise) | (~edge_sel & fall);
   assign w1c      = (write && address == ADDR_EDGE_CAPTURE) ? writedata[WIDTH-1:0] : '0;

   always_comb begin
      rd_value = '0;
      case (reg_addr_e'(address))
         ADDR_DATA:         rd_value[WIDTH-1:0] = data;
         ADDR_IRQ_MASK:     rd_value[WIDTH-1:0] = irq_mask;
         ADDR_EDGE_CAPTURE: rd_value[WIDTH-1:0] = edge_cap;
         ADDR_EDGE_SEL:     rd_value[WIDTH-1:0] = edge_sel;
         default:           rd_value = '0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         irq_mask <= '0;
         edge_sel <= '0;
         edge_cap <= '0;
         readdata <= '0;
         irq      <= 1'b0;
      end else begin
         if (write && address == ADDR_IRQ_MASK) begin
            irq_mask <= writedata[WIDTH-1:0];
         end
         if (write && address == ADDR_EDGE_SEL) begin
            edge_sel <= writedata[WIDTH-1:0];
         end
         // A new edge overrides a simultaneous clear of the same bit.
         edge_cap <= (edge_cap & ~w1c) | edge_hit;
         readdata <= read ? rd_value : '0;
         irq      <= |(edge_cap & irq_mask);
      end
   end

endmodule

// File: tb/tb_input_capture.sv
// Directed bench for input_capture with short tick period: register table,
// debounce/priming sequences, set-wins W1C and mid-operation reset.
module tb_input_capture;
   import input_capture_pkg::*;

   localparam int WIDTH  = 14;
   localparam int TICK   = 8;
   localparam int STABLE = 4;
   localparam int SETTLE = (STABLE + 2) * TICK;

   logic             clk = 1'b0;
   logic             reset;
   logic [WIDTH-1:0] in_raw;
   logic [1:0]       address;
   logic             read;
   logic             write;
   logic [31:0]      writedata;
   logic [31:0]      readdata;
   logic             irq;

   int checks = 0;
   int errors = 0;
   logic [31:0] exp_q[$];
   int m_cnt;

   typedef struct {
      logic        do_write;
      logic [1:0]  addr;
      logic [31:0] wdata;
      logic [31:0] exp;
      string       name;
   } vec_t;

   vec_t vecs[11];

   input_capture #(
      .WIDTH          (WIDTH),
      .TICK_CYCLES    (TICK),
      .STABLE_SAMPLES (STABLE)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .in_raw    (in_raw),
      .address   (address),
      .read      (read),
      .write     (write),
      .writedata (writedata),
      .readdata  (readdata),
      .irq       (irq)
   );

   // Clock and tick-phase reference
   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (reset) m_cnt <= 0;
      else       m_cnt <= (m_cnt == TICK - 1) ? 0 : m_cnt + 1;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
      $fatal(1);
   end

   // Scoreboard
   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Drivers
   task automatic wait_cycles(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic wait_tick();
      do @(negedge clk); while (m_cnt != TICK - 1);
   endtask

   task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
      @(negedge clk);
      address   = a;
      writedata = d;
      write     = 1'b1;
      @(negedge clk);
      write     = 1'b0;
   endtask

   task automatic bus_read(input logic [1:0] a, output logic [31:0] got);
      @(negedge clk);
      address = a;
      read    = 1'b1;
      @(negedge clk);
      read    = 1'b0;
      got     = readdata;
   endtask

   task automatic read_check(input string name, input logic [1:0] a, input logic [31:0] exp);
      logic [31:0] got;
      exp_q.push_back(exp);
      bus_read(a, got);
      check(name, got, exp_q.pop_front());
   endtask

   task automatic wait_irq(input string name, input int budget);
      int n;
      n = 0;
      while (irq !== 1'b1 && n < budget) begin
         @(negedge clk);
         n++;
      end
      check(name, {31'b0, irq}, 32'd1);
   endtask

   initial begin
      vecs[0]  = '{1'b1, ADDR_IRQ_MASK,     32'hFFFF_FFFF, 32'h0000_3FFF, "mask_all"};
      vecs[1]  = '{1'b1, ADDR_DATA,         32'h1234_5678, 32'h0000_3804, "data_wr_ignored"};
      vecs[2]  = '{1'b1, ADDR_EDGE_SEL,     32'hFFFF_FFFF, 32'h0000_3FFF, "sel_all"};
      vecs[3]  = '{1'b1, ADDR_EDGE_SEL,     32'h0000_2AAA, 32'h0000_2AAA, "sel_pattern"};
      vecs[4]  = '{1'b1, ADDR_EDGE_SEL,     32'h0000_0000, 32'h0000_0000, "sel_zero"};
      vecs[5]  = '{1'b0, ADDR_EDGE_CAPTURE, 32'h0000_0000, 32'h0000_0400, "ec_before_w1c"};
      vecs[6]  = '{1'b1, ADDR_EDGE_CAPTURE, 32'h0000_0000, 32'h0000_0400, "ec_w0_keeps"};
      vecs[7]  = '{1'b1, ADDR_EDGE_CAPTURE, 32'hFFFF_C000, 32'h0000_0400, "ec_high_ignored"};
      vecs[8]  = '{1'b1, ADDR_EDGE_CAPTURE, 32'hFFFF_FFFF, 32'h0000_0000, "ec_w1c_all"};
      vecs[9]  = '{1'b1, ADDR_IRQ_MASK,     32'hABCD_0001, 32'h0000_0001, "mask_trunc"};
      vecs[10] = '{1'b1, ADDR_IRQ_MASK,     32'h0000_0400, 32'h0000_0400, "mask_key0"};

      reset     = 1'b1;
      in_raw    = 14'h3C05;
      address   = 2'd0;
      read      = 1'b0;
      write     = 1'b0;
      writedata = 32'h0;
      wait_cycles(3);
      check("reset_readdata", readdata, 32'h0);
      check("reset_irq", {31'b0, irq}, 32'h0);
      reset = 1'b0;

      // Priming after reset
      read_check("data_unprimed", ADDR_DATA, 32'h0);
      read_check("ec_unprimed", ADDR_EDGE_CAPTURE, 32'h0);
      wait_cycles(SETTLE);
      read_check("data_primed", ADDR_DATA, 32'h0000_3C05);
      @(negedge clk);
      check("readdata_idle", readdata, 32'h0);
      read_check("ec_after_prime", ADDR_EDGE_CAPTURE, 32'h0);
      check("irq_after_prime", {31'b0, irq}, 32'h0);

      // Bit0 bounces (never 4 equal samples), then settles low
      for (int c = 0; c < 100; c++) begin
         @(negedge clk);
         if (c % 3 == 2) in_raw[0] = ~in_raw[0];
      end
      in_raw[0] = 1'b0;
      read_check("data_bit0_hold", ADDR_DATA, 32'h0000_3C05);
      wait_cycles(SETTLE);
      read_check("data_bit0_low", ADDR_DATA, 32'h0000_3C04);
      read_check("ec_bit0_fall", ADDR_EDGE_CAPTURE, 32'h0000_0001);
      check("irq_masked_off", {31'b0, irq}, 32'h0);
      bus_write(ADDR_EDGE_CAPTURE, 32'h1);
      read_check("ec_bit0_clear", ADDR_EDGE_CAPTURE, 32'h0);

      // KEY0 falling edge raises irq; W1C clears it
      bus_write(ADDR_IRQ_MASK, 32'h400);
      in_raw[10] = 1'b0;
      wait_irq("irq_key0_fall", 100);
      read_check("ec_key0_fall", ADDR_EDGE_CAPTURE, 32'h0000_0400);
      bus_write(ADDR_EDGE_CAPTURE, 32'h400);
      read_check("ec_key0_clear", ADDR_EDGE_CAPTURE, 32'h0);
      check("irq_key0_clear", {31'b0, irq}, 32'h0);

      // Rising edge ignored with EDGE_SEL=0; re-arm EC[10]
      in_raw[10] = 1'b1;
      wait_cycles(SETTLE);
      read_check("ec_rise_ignored", ADDR_EDGE_CAPTURE, 32'h0);
      in_raw[10] = 1'b0;
      wait_cycles(SETTLE);
      read_check("ec_rearm", ADDR_EDGE_CAPTURE, 32'h0000_0400);
      in_raw[10] = 1'b1;
      wait_cycles(SETTLE);
      check("irq_before_race", {31'b0, irq}, 32'h1);

      // W1C lands on the tick that accepts the next falling edge
      wait_tick();
      in_raw[10] = 1'b0;
      repeat (STABLE) wait_tick();
      address   = ADDR_EDGE_CAPTURE;
      writedata = 32'h400;
      write     = 1'b1;
      @(negedge clk);
      write = 1'b0;
      read_check("ec_set_wins", ADDR_EDGE_CAPTURE, 32'h0000_0400);
      check("irq_set_wins", {31'b0, irq}, 32'h1);

      // Register table
      for (int i = 0; i < 11; i++) begin
         if (vecs[i].do_write) bus_write(vecs[i].addr, vecs[i].wdata);
         read_check(vecs[i].name, vecs[i].addr, vecs[i].exp);
      end

      // Read and write in the same cycle return the pre-write value
      @(negedge clk);
      address   = ADDR_IRQ_MASK;
      writedata = 32'h3FFF;
      read      = 1'b1;
      write     = 1'b1;
      @(negedge clk);
      read  = 1'b0;
      write = 1'b0;
      check("rw_same_cycle", readdata, 32'h0000_0400);
      read_check("rw_after", ADDR_IRQ_MASK, 32'h0000_3FFF);
      bus_write(ADDR_IRQ_MASK, 32'h400);

      // Mid-operation reset with a captured edge and irq asserted
      bus_write(ADDR_EDGE_SEL, 32'h400);
      in_raw[10] = 1'b1;
      wait_irq("irq_key0_rise", 100);
      read_check("ec_key0_rise", ADDR_EDGE_CAPTURE, 32'h0000_0400);
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      check("midreset_irq", {31'b0, irq}, 32'h0);
      check("midreset_readdata", readdata, 32'h0);
      @(negedge clk);
      reset  = 1'b0;
      in_raw = 14'h0155;
      read_check("post_reset_data", ADDR_DATA, 32'h0);
      read_check("post_reset_ec", ADDR_EDGE_CAPTURE, 32'h0);
      read_check("post_reset_mask", ADDR_IRQ_MASK, 32'h0);
      read_check("post_reset_sel", ADDR_EDGE_SEL, 32'h0);
      wait_cycles(SETTLE);
      read_check("reprime_data", ADDR_DATA, 32'h0000_0155);
      read_check("reprime_ec", ADDR_EDGE_CAPTURE, 32'h0);
      check("reprime_irq", {31'b0, irq}, 32'h0);

      // Final report
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
